// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic-array result writeback path.
//   lane_state_e : per-lane fill state (idle, filling, full)
//   bank_depth   : entries per result bank for an M x M matrix over N1 banks
//   bank_aw      : address width for one bank (at least 1 bit)
//   sat_narrow   : clamp a sign-extended value to the signed range of w_out bits
package systolic_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StFull
    } lane_state_e;

    function automatic int unsigned bank_depth(input int unsigned m, input int unsigned n1);
        return (m * m) / n1;
    endfunction

    function automatic int unsigned bank_aw(input int unsigned m, input int unsigned n1);
        int unsigned depth;
        depth = bank_depth(m, n1);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Caller sign-extends its input to longint and keeps the low w_out bits of the result.
    function automatic longint sat_narrow(input longint x, input int unsigned w_out);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w_out - 1)) - 1;
        lo = -hi - 1;
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/wb_lane.sv
// One writeback lane: owns the fill FSM, the linear address counter, the output register
// and the narrowing of the accumulator value for one result bank.
// Narrowing: saturating when RESULT_SAT_EN is defined, plain truncation otherwise.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start_i         arm / re-arm pulse (wins over any coincident valid_i)
//   valid_i, d_i    incoming result and its qualifier
//   wr_en_o         registered bank write enable
//   wr_addr_o       registered bank write address
//   wr_data_o       registered, narrowed bank write data
//   fill_o          lane is armed and not yet full
//   full_o          lane has written its last entry
//   last_o          final accept happens this cycle (combinational)
//   ovr_o           valid_i arrived while unarmed or full (combinational)
module wb_lane
    import systolic_pkg::*;
#(
    parameter int unsigned D_W_ACC = 16,
    parameter int unsigned D_W_OUT = 16,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               valid_i,
    input  logic [D_W_ACC-1:0] d_i,
    output logic               wr_en_o,
    output logic [AW-1:0]      wr_addr_o,
    output logic [D_W_OUT-1:0] wr_data_o,
    output logic               fill_o,
    output logic               full_o,
    output logic               last_o,
    output logic               ovr_o
);

    localparam logic [AW-1:0] LastCnt = AW'(DEPTH - 1);

    lane_state_e        state_q, state_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic               wr_en_q;
    logic [AW-1:0]      wr_addr_q;
    logic [D_W_OUT-1:0] wr_data_q;
    logic [D_W_OUT-1:0] narrow_d;
    logic               accept;

`ifdef RESULT_SAT_EN
    always_comb begin
        narrow_d = D_W_OUT'(sat_narrow(longint'($signed(d_i)), D_W_OUT));
    end
`else
    logic unused_d_hi;
    assign narrow_d    = d_i[D_W_OUT-1:0];
    assign unused_d_hi = ^d_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        last_o  = 1'b0;
        ovr_o   = 1'b0;
        if (start_i) begin
            // Start re-arms and silently drops a coincident result.
            state_d = StFill;
            cnt_d   = '0;
        end else if (valid_i) begin
            if (state_q == StFill) begin
                accept = 1'b1;
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StFull;
                    last_o  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                ovr_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_en_q <= accept;
            if (accept) begin
                wr_addr_q <= cnt_q;
                wr_data_q <= narrow_d;
            end
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign fill_o    = (state_q == StFill);
    assign full_o    = (state_q == StFull);

endmodule

// File: rtl/result_writeback.sv
// Writes per-row systolic-array results into N1 banked result memories (bank i holds matrix
// rows r with r % N1 == i). Lanes run independently, so any row-to-row skew is tolerated.
// Optional feature: define RESULT_SAT_EN for saturating narrowing (default truncates).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      1-cycle pulse: clear counters/flags and arm for a new matrix
//   D, valid_D per-row result values and qualifiers
//   wr_en      bank write enables        wr_addr  bank write addresses
//   wr_data    narrowed bank write data
//   busy       armed and not all banks full
//   done       1-cycle pulse with the final bank write of a completed matrix
//   overrun    sticky: a result arrived on a full or unarmed lane
module result_writeback
    import systolic_pkg::*;
#(
    parameter int unsigned D_W_ACC = 16,
    parameter int unsigned D_W_OUT = 16,
    parameter int unsigned N1      = 4,
    parameter int unsigned N2      = 4,
    parameter int unsigned M       = 8,
    localparam int unsigned AW     = bank_aw(M, N1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [N1-1:0][D_W_ACC-1:0]    D,
    input  logic [N1-1:0]                 valid_D,
    output logic [N1-1:0]                 wr_en,
    output logic [N1-1:0][AW-1:0]         wr_addr,
    output logic [N1-1:0][D_W_OUT-1:0]    wr_data,
    output logic                          busy,
    output logic                          done,
    output logic                          overrun
);

    localparam int unsigned Depth = bank_depth(M, N1);

    if ((M % N1) != 0 || (M % N2) != 0 || D_W_OUT > D_W_ACC) begin : g_bad_cfg
        $error("result_writeback: unsupported parameter combination");
    end

    logic [N1-1:0] fill;
    logic [N1-1:0] full;
    logic [N1-1:0] last;
    logic [N1-1:0] ovr;
    logic          done_q, done_d;
    logic          overrun_q, overrun_d;

    for (genvar i = 0; i < N1; i++) begin : g_lane
        wb_lane #(
            .D_W_ACC (D_W_ACC),
            .D_W_OUT (D_W_OUT),
            .DEPTH   (Depth),
            .AW      (AW)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .start_i   (start),
            .valid_i   (valid_D[i]),
            .d_i       (D[i]),
            .wr_en_o   (wr_en[i]),
            .wr_addr_o (wr_addr[i]),
            .wr_data_o (wr_data[i]),
            .fill_o    (fill[i]),
            .full_o    (full[i]),
            .last_o    (last[i]),
            .ovr_o     (ovr[i])
        );
    end

    always_comb begin
        // Done only when this cycle's final accept(s) complete the last outstanding lanes;
        // a coincident start aborts the run and suppresses done.
        done_d    = !start && (&(full | last)) && (|last);
        overrun_d = start ? 1'b0 : (overrun_q | (|ovr));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy    = |fill;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback (M=8, N1=4, N2=4, 16 entries per bank, 16->8 bit data).
module tb_result_writeback;

    localparam int N1 = 4;
    localparam int AW = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [N1-1:0][15:0]   D;
    logic [N1-1:0]         valid_D;
    logic [N1-1:0]         wr_en;
    logic [N1-1:0][AW-1:0] wr_addr;
    logic [N1-1:0][7:0]    wr_data;
    logic                  busy;
    logic                  done;
    logic                  overrun;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] d;
        logic [7:0]  exp_trunc;
        logic [7:0]  exp_sat;
    } nar_vec_t;

    nar_vec_t nv [8];

    result_writeback #(
        .D_W_ACC (16),
        .D_W_OUT (8),
        .N1      (4),
        .N2      (4),
        .M       (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .D       (D),
        .valid_D (valid_D),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start   = 1'b1;
        valid_D = '0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        nv[0] = '{16'h0190, 8'h90, 8'h7F};
        nv[1] = '{16'hFF00, 8'h00, 8'h80};
        nv[2] = '{16'h007F, 8'h7F, 8'h7F};
        nv[3] = '{16'hFF80, 8'h80, 8'h80};
        nv[4] = '{16'h0080, 8'h80, 8'h7F};
        nv[5] = '{16'hFF7F, 8'h7F, 8'h80};
        nv[6] = '{16'h0005, 8'h05, 8'h05};
        nv[7] = '{16'hFFFD, 8'hFD, 8'hFD};

        rst = 1'b1; start = 1'b0; valid_D = '0; D = '0;
        #2;
        check("reset wr_en", 32'(wr_en), 0);
        check("reset wr_addr", 32'(wr_addr), 0);
        check("reset wr_data", 32'(wr_data), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset overrun", 32'(overrun), 0);
        tick(); tick();
        rst = 1'b0;

        // Valid while unarmed flags overrun without a write.
        valid_D = 4'b0100; D[2] = 16'h0042;
        tick();
        valid_D = '0;
        check("unarmed wr_en", 32'(wr_en), 0);
        check("unarmed overrun", 32'(overrun), 1);
        check("unarmed busy", 32'(busy), 0);

        // Reset mid-fill with lane 0 at count 7.
        pulse_start();
        check("t1 start overrun clr", 32'(overrun), 0);
        check("t1 start busy", 32'(busy), 1);
        for (int k = 0; k < 7; k++) begin
            valid_D = 4'b0001; D[0] = 16'(k);
            tick();
            check($sformatf("t1 en k%0d", k), 32'(wr_en), 1);
            check($sformatf("t1 addr k%0d", k), 32'(wr_addr[0]), 32'(k));
        end
        valid_D = '0;
        #2 rst = 1'b1;
        #1;
        check("t1 rst wr_en", 32'(wr_en), 0);
        check("t1 rst wr_addr", 32'(wr_addr), 0);
        check("t1 rst wr_data", 32'(wr_data), 0);
        check("t1 rst busy", 32'(busy), 0);
        check("t1 rst done", 32'(done), 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t1 no done %0d", k), 32'(done), 0);
        end

        // All lanes in lockstep.
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            valid_D = 4'hF;
            for (int i = 0; i < N1; i++) D[i] = 16'(k + 20 * i);
            tick();
            for (int i = 0; i < N1; i++) begin
                check($sformatf("t2 en l%0d k%0d", i, k), 32'(wr_en[i]), 1);
                check($sformatf("t2 addr l%0d k%0d", i, k), 32'(wr_addr[i]), 32'(k));
                check($sformatf("t2 data l%0d k%0d", i, k), 32'(wr_data[i]), 32'(k + 20 * i));
            end
            check($sformatf("t2 done k%0d", k), 32'(done), 32'(k == 15));
            check($sformatf("t2 busy k%0d", k), 32'(busy), 32'(k != 15));
        end
        valid_D = '0;
        tick();
        check("t2 after en", 32'(wr_en), 0);
        check("t2 after done", 32'(done), 0);
        check("t2 after busy", 32'(busy), 0);

        // Lane i skewed by i cycles.
        pulse_start();
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < N1; i++) begin
                valid_D[i] = (c >= i) && (c < i + 16);
                D[i] = 16'((c - i) * 5 + i);
            end
            tick();
            for (int i = 0; i < N1; i++) begin
                logic in_win;
                in_win = (c >= i) && (c < i + 16);
                check($sformatf("t3 en l%0d c%0d", i, c), 32'(wr_en[i]), 32'(in_win));
                if (in_win) begin
                    check($sformatf("t3 addr l%0d c%0d", i, c), 32'(wr_addr[i]), 32'(c - i));
                    check($sformatf("t3 data l%0d c%0d", i, c), 32'(wr_data[i]),
                          32'((c - i) * 5 + i));
                end
            end
            check($sformatf("t3 done c%0d", c), 32'(done), 32'(c == 18));
            check($sformatf("t3 busy c%0d", c), 32'(busy), 32'(c < 18));
        end
        valid_D = '0;

        // 17th result on full lane 2 while lane 0 still fills.
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            valid_D = 4'b0100; D[2] = 16'(k);
            tick();
            check($sformatf("t4 en k%0d", k), 32'(wr_en), 32'h4);
        end
        valid_D = 4'b0101; D[0] = 16'h0011; D[2] = 16'h0022;
        tick();
        valid_D = '0;
        check("t4 ovr wr_en", 32'(wr_en), 32'h1);
        check("t4 ovr addr0", 32'(wr_addr[0]), 0);
        check("t4 ovr data0", 32'(wr_data[0]), 32'h11);
        check("t4 overrun", 32'(overrun), 1);
        check("t4 busy", 32'(busy), 1);
        check("t4 done", 32'(done), 0);
        tick();
        check("t4 overrun sticky", 32'(overrun), 1);

        // Narrowing table on lane 0.
        pulse_start();
        check("t5 start clears overrun", 32'(overrun), 0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp;
`ifdef RESULT_SAT_EN
            exp = nv[i].exp_sat;
`else
            exp = nv[i].exp_trunc;
`endif
            valid_D = 4'b0001; D[0] = nv[i].d;
            tick();
            check($sformatf("t5 data %0h", nv[i].d), 32'(wr_data[0]), 32'(exp));
            check($sformatf("t5 addr %0d", i), 32'(wr_addr[0]), 32'(i));
        end
        valid_D = '0;

        // Start mid-matrix with lane 1 at count 9 and coincident valids.
        pulse_start();
        for (int k = 0; k < 9; k++) begin
            valid_D = 4'b0010; D[1] = 16'(k);
            tick();
        end
        start = 1'b1; valid_D = 4'hF;
        tick();
        start = 1'b0; valid_D = '0;
        check("t6 dropped wr_en", 32'(wr_en), 0);
        check("t6 overrun", 32'(overrun), 0);
        check("t6 busy", 32'(busy), 1);
        valid_D = 4'b0010; D[1] = 16'h0033;
        tick();
        valid_D = '0;
        check("t6 restart en", 32'(wr_en), 32'h2);
        check("t6 restart addr", 32'(wr_addr[1]), 0);
        check("t6 restart data", 32'(wr_data[1]), 32'h33);

        // Start coincident with the final accept: start wins, no done.
        pulse_start();
        for (int k = 0; k < 15; k++) begin
            valid_D = 4'hF;
            tick();
        end
        start = 1'b1; valid_D = 4'hF;
        tick();
        start = 1'b0; valid_D = '0;
        check("t7 done", 32'(done), 0);
        check("t7 wr_en", 32'(wr_en), 0);
        check("t7 busy", 32'(busy), 1);
        check("t7 overrun", 32'(overrun), 0);
        tick();
        check("t7 done later", 32'(done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
